// File: rtl/stack_pkg.sv
// ----------------------------------------------------------------------------
// stack_pkg
// Shared types for the stack ALU unit:
//   op_e      - 3-bit command opcode (PUSH/POP/DUP/SWAP/ADD/SUB/AND/NOT)
//   state_e   - control FSM state (IDLE/EXEC)
//   cmd_fault - legality check of an opcode against the current fill level,
//               returning {overflow, underflow}
// ----------------------------------------------------------------------------
package stack_pkg;

   typedef enum logic [2:0] {
      OP_PUSH = 3'd0,
      OP_POP  = 3'd1,
      OP_DUP  = 3'd2,
      OP_SWAP = 3'd3,
      OP_ADD  = 3'd4,
      OP_SUB  = 3'd5,
      OP_AND  = 3'd6,
      OP_NOT  = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

   // Returns {ovf, udf}. At most one bit is ever set: a command either needs
   // more free slots than exist or more stored entries than exist.
   function automatic logic [1:0] cmd_fault(op_e op, int unsigned cnt, int unsigned depth);
      logic ovf;
      logic udf;
      ovf = 1'b0;
      udf = 1'b0;
      case (op)
         OP_PUSH: ovf = (cnt >= depth);
         OP_POP,
         OP_NOT:  udf = (cnt < 1);
         OP_DUP: begin
            // An empty stack has nothing to copy; that takes precedence.
            if (cnt < 1)           udf = 1'b1;
            else if (cnt >= depth) ovf = 1'b1;
         end
         default: udf = (cnt < 2);   // SWAP, ADD, SUB, AND
      endcase
      return {ovf, udf};
   endfunction

endpackage

// File: rtl/stack_alu.sv
// ----------------------------------------------------------------------------
// stack_alu
// Combinational datapath for the two-operand and one-operand stack ops.
// Ports:
//   op_i   - opcode (only ADD/SUB/AND/NOT are meaningful)
//   nos_i  - next-on-stack operand
//   tos_i  - top-of-stack operand
//   res_o  - NOS op TOS (or ~TOS for NOT); carry/borrow discarded
// ----------------------------------------------------------------------------
module stack_alu
   import stack_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op_i,
   input  logic [WIDTH-1:0] nos_i,
   input  logic [WIDTH-1:0] tos_i,
   output logic [WIDTH-1:0] res_o
);

   always_comb begin
      res_o = tos_i;
      case (op_i)
         OP_ADD:  res_o = nos_i + tos_i;
         OP_SUB:  res_o = nos_i - tos_i;
         OP_AND:  res_o = nos_i & tos_i;
         OP_NOT:  res_o = ~tos_i;
         default: res_o = tos_i;
      endcase
   end

endmodule

// File: rtl/stack_alu_unit.sv
// ----------------------------------------------------------------------------
// stack_alu_unit
// Small hardware stack with an integrated ALU. Commands are accepted in IDLE
// and executed in the following EXEC cycle; results and the completion pulse
// appear together one clock after accept.
// Ports:
//   clk, rst            - clock; asynchronous active-low reset
//   cmd_valid/cmd_ready - command handshake (ready only in IDLE)
//   cmd_op, cmd_data    - opcode and PUSH operand
//   rsp_valid, rsp_err  - one-cycle completion pulse and reject flag
//   tos, tos_zero       - top of stack (0 when empty) and its zero test
//   count, empty, full  - fill level and its boundaries
//   err_ovf, err_udf    - sticky overflow / underflow flags
//   clr_err             - synchronous clear of the sticky flags
// ----------------------------------------------------------------------------
module stack_alu_unit
   import stack_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [2:0]                 cmd_op,
   input  logic [WIDTH-1:0]           cmd_data,
   output logic                       rsp_valid,
   output logic                       rsp_err,
   output logic [WIDTH-1:0]           tos,
   output logic                       tos_zero,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       err_ovf,
   output logic                       err_udf,
   input  logic                       clr_err
);

   localparam int CW = $clog2(DEPTH+1);
   // The entries below TOS live in DEPTH-1 slots; keep the index at least 1 bit.
   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH-1) : 1;

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ovf_q, ovf_d;       // fault classification taken at accept
   logic             udf_q, udf_d;
   logic [WIDTH-1:0] tos_q, tos_d;
   logic [CW-1:0]    count_q, count_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_err_q, rsp_err_d;
   logic             err_ovf_q, err_ovf_d;
   logic             err_udf_q, err_udf_d;

   logic [WIDTH-1:0] stk_q [DEPTH-1];
   logic             stk_we;
   logic [AW-1:0]    stk_widx;
   logic [WIDTH-1:0] stk_wdata;

   logic             accept;
   logic [1:0]       fault;
   logic [AW-1:0]    nos_idx;
   logic [AW-1:0]    free_idx;
   logic [WIDTH-1:0] nos;
   logic [WIDTH-1:0] alu_res;
   logic             exec_set_ovf;
   logic             exec_set_udf;

   assign cmd_ready = (state_q == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign fault     = cmd_fault(op_e'(cmd_op), 32'(count_q), DEPTH);

   // With count entries stored, slot count-2 holds NOS and slot count-1 is
   // where the old TOS goes when a new value is pushed over it.
   assign nos_idx  = AW'(count_q) - AW'(2);
   assign free_idx = AW'(count_q) - AW'(1);
   assign nos      = stk_q[nos_idx];

   stack_alu #(.WIDTH(WIDTH)) u_alu (
      .op_i  (op_q),
      .nos_i (nos),
      .tos_i (tos_q),
      .res_o (alu_res)
   );

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      data_d       = data_q;
      ovf_d        = ovf_q;
      udf_d        = udf_q;
      tos_d        = tos_q;
      count_d      = count_q;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = 1'b0;
      stk_we       = 1'b0;
      stk_widx     = free_idx;
      stk_wdata    = tos_q;
      exec_set_ovf = 1'b0;
      exec_set_udf = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d    = op_e'(cmd_op);
               data_d  = cmd_data;
               ovf_d   = fault[1];
               udf_d   = fault[0];
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d      = ST_IDLE;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = ovf_q | udf_q;
            exec_set_ovf = ovf_q;
            exec_set_udf = udf_q;
            if (!(ovf_q || udf_q)) begin
               case (op_q)
                  OP_PUSH: begin
                     stk_we  = (count_q != '0);   // nothing to save under an empty top
                     tos_d   = data_q;
                     count_d = count_q + CW'(1);
                  end
                  OP_POP: begin
                     tos_d   = nos;
                     count_d = count_q - CW'(1);
                  end
                  OP_DUP: begin
                     stk_we  = 1'b1;
                     count_d = count_q + CW'(1);
                  end
                  OP_SWAP: begin
                     stk_we   = 1'b1;
                     stk_widx = nos_idx;
                     tos_d    = nos;
                  end
                  OP_NOT: begin
                     tos_d = alu_res;
                  end
                  default: begin                 // ADD, SUB, AND
                     tos_d   = alu_res;
                     count_d = count_q - CW'(1);
                  end
               endcase
            end
            // An empty stack always reads back 0, whatever the slot held.
            if (count_d == '0) tos_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase

      // A fault being recorded this cycle beats a simultaneous clear.
      err_ovf_d = exec_set_ovf | (err_ovf_q & ~clr_err);
      err_udf_d = exec_set_udf | (err_udf_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_PUSH;
         data_q      <= '0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         tos_q       <= '0;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_udf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         tos_q       <= tos_d;
         count_q     <= count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         err_ovf_q   <= err_ovf_d;
         err_udf_q   <= err_udf_d;
      end
   end

   // Storage is not reset; writes only happen from EXEC, and reset forces
   // IDLE, so an abandoned command can never disturb it.
   always_ff @(posedge clk) begin
      if (stk_we) stk_q[stk_widx] <= stk_wdata;
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign tos       = tos_q;
   assign tos_zero  = (tos_q == '0);
   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign err_ovf   = err_ovf_q;
   assign err_udf   = err_udf_q;

endmodule

// File: tb/tb_stack_alu_unit.sv
module tb_stack_alu_unit;
   import stack_pkg::*;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_op = 3'd0;
   logic [W-1:0] cmd_data = '0;
   logic         rsp_valid, rsp_err;
   logic [W-1:0] tos;
   logic         tos_zero;
   logic [2:0]   count;
   logic         empty, full, err_ovf, err_udf;
   logic         clr_err = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stack_alu_unit #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err),
      .tos(tos), .tos_zero(tos_zero), .count(count),
      .empty(empty), .full(full),
      .err_ovf(err_ovf), .err_udf(err_udf),
      .clr_err(clr_err)
   );

   typedef struct {
      logic [2:0] op;
      logic [7:0] data;
      logic       err;
      logic [7:0] tos;
      int         cnt;
      logic       ovf;
      logic       udf;
   } vec_t;

   vec_t vecs[26];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cmd_valid = 1'b0;
      clr_err = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Issues one command and returns after its completion cycle has been sampled.
   task automatic run_cmd(input logic [2:0] op, input logic [7:0] data,
                          input logic clr, output logic got_err);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_before_accept", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      clr_err   = clr;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("exec_rsp_err", rsp_err, 0);
      chk("exec_cmd_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      chk("rsp_valid_latency", rsp_valid, 1);
      got_err = rsp_err;
   endtask

   task automatic check_state(input string tag, input logic got_err, input logic e_err,
                              input logic [7:0] e_tos, input int e_cnt,
                              input logic e_ovf, input logic e_udf);
      chk({tag, "_rsp_err"}, got_err, e_err);
      chk({tag, "_tos"}, tos, e_tos);
      chk({tag, "_count"}, count, e_cnt);
      chk({tag, "_tos_zero"}, tos_zero, (e_tos == 8'h00));
      chk({tag, "_empty"}, empty, (e_cnt == 0));
      chk({tag, "_full"}, full, (e_cnt == D));
      chk({tag, "_err_ovf"}, err_ovf, e_ovf);
      chk({tag, "_err_udf"}, err_udf, e_udf);
   endtask

   // Reference model: the stack as a queue, back = top of stack.
   logic [7:0] mq[$];
   logic       m_ovf, m_udf;

   task automatic model_apply(input logic [2:0] op, input logic [7:0] data, input logic clr,
                              output logic e_err);
      logic ovf, udf;
      logic [7:0] t, s;
      int n;
      n = mq.size();
      ovf = 1'b0;
      udf = 1'b0;
      case (op)
         3'd0: ovf = (n >= D);
         3'd1, 3'd7: udf = (n < 1);
         3'd2: begin
            if (n < 1) udf = 1'b1;
            else if (n >= D) ovf = 1'b1;
         end
         default: udf = (n < 2);
      endcase
      e_err = ovf | udf;
      if (!e_err) begin
         case (op)
            3'd0: mq.push_back(data);
            3'd1: t = mq.pop_back();
            3'd2: mq.push_back(mq[n-1]);
            3'd3: begin t = mq.pop_back(); s = mq.pop_back(); mq.push_back(t); mq.push_back(s); end
            3'd4: begin t = mq.pop_back(); s = mq.pop_back(); mq.push_back(8'(s + t)); end
            3'd5: begin t = mq.pop_back(); s = mq.pop_back(); mq.push_back(8'(s - t)); end
            3'd6: begin t = mq.pop_back(); s = mq.pop_back(); mq.push_back(s & t); end
            default: begin t = mq.pop_back(); mq.push_back(~t); end
         endcase
      end
      m_ovf = ovf | (m_ovf & ~clr);
      m_udf = udf | (m_udf & ~clr);
   endtask

   initial begin
      logic       got;
      logic       e_err;
      logic [7:0] e_tos;
      logic [2:0] op;
      logic [7:0] data;
      logic       clr;

      vecs[0]  = '{OP_PUSH, 8'h05, 0, 8'h05, 1, 0, 0};
      vecs[1]  = '{OP_PUSH, 8'h03, 0, 8'h03, 2, 0, 0};
      vecs[2]  = '{OP_SUB,  8'h00, 0, 8'h02, 1, 0, 0};
      vecs[3]  = '{OP_POP,  8'h00, 0, 8'h00, 0, 0, 0};
      vecs[4]  = '{OP_POP,  8'h00, 1, 8'h00, 0, 0, 1};
      vecs[5]  = '{OP_PUSH, 8'h0F, 0, 8'h0F, 1, 0, 1};
      vecs[6]  = '{OP_PUSH, 8'hF1, 0, 8'hF1, 2, 0, 1};
      vecs[7]  = '{OP_ADD,  8'h00, 0, 8'h00, 1, 0, 1};
      vecs[8]  = '{OP_POP,  8'h00, 0, 8'h00, 0, 0, 1};
      vecs[9]  = '{OP_PUSH, 8'h01, 0, 8'h01, 1, 0, 1};
      vecs[10] = '{OP_PUSH, 8'h02, 0, 8'h02, 2, 0, 1};
      vecs[11] = '{OP_SWAP, 8'h00, 0, 8'h01, 2, 0, 1};
      vecs[12] = '{OP_POP,  8'h00, 0, 8'h02, 1, 0, 1};
      vecs[13] = '{OP_NOT,  8'h00, 0, 8'hFD, 1, 0, 1};
      vecs[14] = '{OP_DUP,  8'h00, 0, 8'hFD, 2, 0, 1};
      vecs[15] = '{OP_PUSH, 8'h30, 0, 8'h30, 3, 0, 1};
      vecs[16] = '{OP_PUSH, 8'h0C, 0, 8'h0C, 4, 0, 1};
      vecs[17] = '{OP_PUSH, 8'h09, 1, 8'h0C, 4, 1, 1};
      vecs[18] = '{OP_DUP,  8'h00, 1, 8'h0C, 4, 1, 1};
      vecs[19] = '{OP_AND,  8'h00, 0, 8'h00, 3, 1, 1};
      vecs[20] = '{OP_SUB,  8'h00, 0, 8'hFD, 2, 1, 1};
      vecs[21] = '{OP_ADD,  8'h00, 0, 8'hFA, 1, 1, 1};
      vecs[22] = '{OP_SWAP, 8'h00, 1, 8'hFA, 1, 1, 1};
      vecs[23] = '{OP_POP,  8'h00, 0, 8'h00, 0, 1, 1};
      vecs[24] = '{OP_NOT,  8'h00, 1, 8'h00, 0, 1, 1};
      vecs[25] = '{OP_DUP,  8'h00, 1, 8'h00, 0, 1, 1};

      // Reset state
      do_reset();
      #1;
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_err", rsp_err, 0);
      check_state("reset", 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);

      // Directed table
      for (int i = 0; i < 26; i++) begin
         run_cmd(vecs[i].op, vecs[i].data, 1'b0, got);
         $display("vec %0d op=%0d data=%02h -> err=%0b tos=%02h count=%0d ovf=%0b udf=%0b",
                  i, vecs[i].op, vecs[i].data, got, tos, count, err_ovf, err_udf);
         check_state($sformatf("vec%0d", i), got, vecs[i].err, vecs[i].tos, vecs[i].cnt,
                     vecs[i].ovf, vecs[i].udf);
      end

      // Set wins over a simultaneous clear: illegal POP on empty with clr_err held
      run_cmd(OP_POP, 8'h00, 1'b1, got);
      $display("pop with clr_err held -> err=%0b ovf=%0b udf=%0b", got, err_ovf, err_udf);
      check_state("setwins", got, 1'b1, 8'h00, 0, 1'b0, 1'b1);

      // Overflow after filling, then clr_err pulse
      do_reset();
      for (int i = 0; i < D; i++) begin
         run_cmd(OP_PUSH, 8'(8'h10 + i), 1'b0, got);
         $display("fill push %0d -> err=%0b count=%0d", i, got, count);
      end
      run_cmd(OP_PUSH, 8'h09, 1'b0, got);
      $display("push 9 on full -> err=%0b tos=%02h count=%0d ovf=%0b", got, tos, count, err_ovf);
      check_state("ovf", got, 1'b1, 8'h13, D, 1'b1, 1'b0);
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      $display("clr_err -> ovf=%0b udf=%0b", err_ovf, err_udf);
      chk("clr_err_ovf", err_ovf, 0);
      chk("clr_err_udf", err_udf, 0);
      chk("clr_err_count_kept", count, D);

      // Reset during EXEC abandons the command
      do_reset();
      run_cmd(OP_PUSH, 8'h44, 1'b0, got);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_PUSH;
      cmd_data  = 8'h07;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("rstexec_in_exec", cmd_ready, 0);
      rst = 1'b0;
      #1;
      chk("rstexec_count", count, 0);
      chk("rstexec_tos", tos, 0);
      chk("rstexec_rsp_valid", rsp_valid, 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("rstexec_no_rsp", rsp_valid, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstexec_ready_after", cmd_ready, 1);
      @(posedge clk);
      #1;
      $display("reset in exec -> rsp_valid=%0b count=%0d tos=%02h ready=%0b",
               rsp_valid, count, tos, cmd_ready);
      chk("rstexec_no_late_rsp", rsp_valid, 0);
      chk("rstexec_count_after", count, 0);
      chk("rstexec_tos_after", tos, 0);

      // Randomized against the queue model
      do_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      for (int i = 0; i < 300; i++) begin
         op   = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) op = OP_PUSH;
         data = 8'($urandom);
         clr  = ($urandom_range(0, 7) == 0);
         run_cmd(op, data, clr, got);
         model_apply(op, data, clr, e_err);
         e_tos = (mq.size() == 0) ? 8'h00 : mq[mq.size()-1];
         $display("rnd %0d op=%0d data=%02h clr=%0b -> err=%0b tos=%02h count=%0d",
                  i, op, data, clr, got, tos, count);
         check_state($sformatf("rnd%0d", i), got, e_err, e_tos, mq.size(), m_ovf, m_udf);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
